flags_ctrl: RTL
===============

# flags_ctrl

Sequencer and arbiter for the 3-bit processor flags register (Z, N, C). It sits between the execute stage, the carry-manipulation instructions and the interrupt unit. Every cycle it picks at most one source to drive the flags register load port. It also keeps a shadow stack so flags survive interrupt entry and return, including nested interrupts.

## Interface
Parameters:
- DEPTH, 4, shadow stack entries (maximum interrupt nesting level); 1..8
- PTR_W, 3, stack pointer width; must satisfy 2^PTR_W > DEPTH

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  execute stage has a flag result this cycle
- alu_z, alu_n, alu_c  in  1 each  flag result from the execute stage
- setc, clrc  in  1 each  set-carry / clear-carry instruction retiring
- int_save  in  1  single-cycle pulse: interrupt entry, push current flags
- rti_req  in  1  return-from-interrupt request; held until rti_ack
- rti_ack  out  1  single-cycle pulse: restore completed
- busy  out  1  restore in progress; execute stage must stall flag writers
- z, n, c  in  1 each  current flags register outputs
- flags_enable  out  1  flags register load strobe
- flags_zi, flags_ni, flags_ci, flags_sc  out  1 each  flags register data inputs
- depth  out  PTR_W  current shadow stack occupancy
- ovf_err, udf_err  out  1 each  sticky overflow / underflow errors; cleared only by rst

## Operation
- Reset values:
  - state IDLE; depth 0; ovf_err = udf_err = 0
  - rti_ack = busy = 0
  - flags_enable and all flag data outputs 0 while rst is high
- State machine has three states: IDLE, RST_RD, RST_WR.
- IDLE load-source priority: alu_valid > setc > clrc. Lower-priority requests in the same cycle are dropped.
  - alu_valid: drive flags_zi/ni/ci = alu_z/n/c, flags_sc = 0, flags_enable = 1.
  - setc: drive flags_zi = z, flags_ni = n, flags_sc = 1, flags_ci = 0.
  - clrc: drive flags_zi = z, flags_ni = n, flags_ci = 0, flags_sc = 0.
  - Z and N always hold their value on setc/clrc.
- int_save (accepted in any state):
  - Pushes the value the flags register will hold after this edge: the IDLE-selected write if flags_enable = 1, otherwise {z, n, c}.
  - Then depth increments.
  - If depth == DEPTH: the push is dropped, depth is unchanged and ovf_err is set.
- rti_req seen in IDLE:
  - depth == 0: rti_ack pulses next cycle, flags unchanged, udf_err set.
  - Otherwise: go to RST_RD. A same-cycle alu/setc/clrc write is still performed.
- RST_RD:
  - busy = 1.
  - Top entry is read into a data register; depth decrements.
  - Go to RST_WR.
- RST_WR:
  - busy = 1.
  - flags_enable = 1 with the registered entry; flags_sc = 0.
  - rti_ack = 1.
  - Go to IDLE.
- alu_valid/setc/clrc asserted while busy = 1 is a protocol violation. They are ignored and no error flag is raised.
- int_save during RST_RD: the push is applied after the pop. Net depth is unchanged and the top entry is overwritten.
- rst mid-restore returns to IDLE and empties the stack; no rti_ack is issued.

## Timing
- Source to flags register: flags_enable and data are combinational from the IDLE requests. The flags register shows the new value one clock after the request.
- rti_req in IDLE to rti_ack: 2 cycles (RST_RD, then RST_WR). Restored flags are visible on z/n/c at cycle 3.
- busy is high for exactly 2 cycles per non-empty restore.
- depth updates on the edge where the push or pop is accepted.
- rti_req must be deasserted the cycle after rti_ack. If it is still high in IDLE, it starts a new restore.

## Configuration
- FLAGS_SHADOW_EN defined: shadow stack, RST_RD/RST_WR states, depth and both error flags are present, as described above.
- FLAGS_SHADOW_EN undefined:
  - No stack is built and int_save is ignored.
  - rti_req is acked the next cycle with flags unchanged; busy stays 0.
  - depth, ovf_err and udf_err are tied to 0.
  - Source arbitration is identical.

## Structure
- Shared package flags_pkg holds:
  - state encodings (IDLE = 2'd0, RST_RD = 2'd1, RST_WR = 2'd2)
  - flag bit indexes (Z = 2, N = 1, C = 0) matching the flags register packing {z, n, c}
- Sub-module flags_shadow_stack:
  - DEPTH x 3-bit LIFO with push, pop, push-during-pop, full and empty
  - registered read data
  - instantiated only under FLAGS_SHADOW_EN

## Test plan
- Reset, then alu_valid with z=1, n=0, c=1 and setc in the same cycle → flags_enable = 1 with alu data only. Next cycle z/n/c = 1/0/1.
- Flags 0/1/0, setc → flags_sc = 1; next cycle flags 0/1/1. Then clrc → flags 0/1/0.
- int_save with flags 1/0/0, alu writes 0/1/1, rti_req → busy high 2 cycles, rti_ack at cycle 2, flags 1/0/0 at cycle 3, depth 1 → 0.
- DEPTH = 4: 5 int_save pulses → depth = 4 and ovf_err = 1. Then 4 restores return the entries in LIFO order.
- rti_req with depth 0 → rti_ack next cycle, flags unchanged, udf_err = 1, busy stays 0.
- Assert rst during RST_RD → next cycle state IDLE, depth 0, rti_ack never pulses, errors cleared.

Source files
------------

// File: rtl/flags_pkg.sv
// flags_pkg: shared types and constants for the flags register sequencer.
// Used by flags_ctrl and flags_shadow_stack. The shadow stack only exists
// when the design is built with FLAGS_SHADOW_EN defined.
package flags_pkg;

    // Sequencer states. Encodings are fixed so that debug tooling can decode them.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RST_RD = 2'd1,
        RST_WR = 2'd2
    } state_t;

    // Flags register packing is {z, n, c}.
    typedef logic [2:0] flags_t;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    // Pack the three live flag bits in register order.
    function automatic flags_t pack_flags(input logic z, input logic n, input logic c);
        flags_t f;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        return f;
    endfunction

    // Value the flags register captures from its load port: the set-carry
    // input forces C high, otherwise C follows the carry data input.
    function automatic flags_t load_value(input logic zi, input logic ni,
                                          input logic ci, input logic sc);
        return pack_flags(zi, ni, ci | sc);
    endfunction

endpackage

// File: rtl/flags_ctrl_if.sv
// flags_ctrl_if: request/handshake bundle between the pipeline, the interrupt
// unit and the flags register on one side (master) and flags_ctrl (slave).
interface flags_ctrl_if;

    // Flag writers from the execute stage and carry instructions
    logic alu_valid;
    logic alu_z;
    logic alu_n;
    logic alu_c;
    logic setc;
    logic clrc;

    // Interrupt entry / return handshake
    logic int_save;
    logic rti_req;
    logic rti_ack;
    logic busy;

    // Flags register: current outputs and load port
    logic z;
    logic n;
    logic c;
    logic flags_enable;
    logic flags_zi;
    logic flags_ni;
    logic flags_ci;
    logic flags_sc;

    modport master (
        output alu_valid, alu_z, alu_n, alu_c, setc, clrc,
        output int_save, rti_req,
        output z, n, c,
        input  rti_ack, busy,
        input  flags_enable, flags_zi, flags_ni, flags_ci, flags_sc
    );

    modport slave (
        input  alu_valid, alu_z, alu_n, alu_c, setc, clrc,
        input  int_save, rti_req,
        input  z, n, c,
        output rti_ack, busy,
        output flags_enable, flags_zi, flags_ni, flags_ci, flags_sc
    );

endinterface

// File: rtl/flags_shadow_stack.sv
// flags_shadow_stack: DEPTH x 3-bit LIFO holding flags across interrupt
// entry/return. Supports push, pop and push-during-pop (pop reads the old
// top, the push then overwrites that slot). Read data is registered.
// Instantiated by flags_ctrl only when FLAGS_SHADOW_EN is defined.
module flags_shadow_stack
    import flags_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  flags_t           push_data,
    output flags_t           pop_data,
    output logic [PTR_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             push_drop
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << AW;

    flags_t           mem [SLOTS];
    logic [PTR_W-1:0] count_q;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count_q == PTR_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the top slot, so a full stack still
    // accepts the push.
    assign push_ok = push && (!full || pop_ok);
    assign push_drop = push && !push_ok;

    assign top_idx = AW'(count_q - 1'b1);
    assign wr_idx  = pop_ok ? top_idx : AW'(count_q);

    assign count = count_q;

    // Storage array: written on an accepted push.
    // NOTE: the array has no reset; count_q decides which slots hold valid data,
    // so clearing the contents would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Occupancy counter and registered read port.
    // NOTE: sequential state uses non-blocking assignments so the read of the
    // old top and the overwrite in a push-during-pop see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            pop_data <= '0;
        end else begin
            if (pop_ok) begin
                pop_data <= mem[top_idx];
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/flags_ctrl.sv
// flags_ctrl: arbitrates the flags register load port between the execute
// stage and the set/clear-carry instructions, and sequences flag save/restore
// around interrupts.
// Build option FLAGS_SHADOW_EN: when defined, a shadow stack saves flags on
// int_save and restores them on rti_req (two-cycle RST_RD/RST_WR sequence).
// When undefined, int_save is ignored and rti_req is acked the next cycle
// with no flag change; depth and the error flags read as zero.
module flags_ctrl
    import flags_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    flags_ctrl_if.slave      bus,
    output logic [PTR_W-1:0] depth,
    output logic             ovf_err,
    output logic             udf_err
);

    state_t state;
    logic   busy_q;
    logic   ack_q;
    flags_t restore_data;

    logic   load_en;
    logic   load_zi;
    logic   load_ni;
    logic   load_ci;
    logic   load_sc;

    assign bus.flags_enable = load_en;
    assign bus.flags_zi     = load_zi;
    assign bus.flags_ni     = load_ni;
    assign bus.flags_ci     = load_ci;
    assign bus.flags_sc     = load_sc;
    assign bus.busy         = busy_q;
    assign bus.rti_ack      = ack_q;

`ifdef FLAGS_SHADOW_EN
    logic             stack_pop;
    logic             stack_full;
    logic             stack_empty;
    logic             push_drop;
    logic [PTR_W-1:0] stack_count;
    flags_t           next_flags;
    logic             ovf_q;
    logic             udf_q;

    // A save captures what the flags register holds after this edge, so a
    // write performed in the same cycle is included.
    assign next_flags = load_en ? load_value(load_zi, load_ni, load_ci, load_sc)
                                : pack_flags(bus.z, bus.n, bus.c);
    assign stack_pop  = (state == RST_RD);

    flags_shadow_stack #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.int_save),
        .pop       (stack_pop),
        .push_data (next_flags),
        .pop_data  (restore_data),
        .count     (stack_count),
        .full      (stack_full),
        .empty     (stack_empty),
        .push_drop (push_drop)
    );

    assign depth   = stack_count;
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

    logic unused_full;
    assign unused_full = stack_full;
`else
    assign restore_data = '0;
    assign depth        = '0;
    assign ovf_err      = 1'b0;
    assign udf_err      = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{bus.int_save, bus.c, 32'(DEPTH)};
`endif

    // Load-port arbitration: one writer per cycle, restore owns the port in RST_WR.
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        load_en = 1'b0;
        load_zi = 1'b0;
        load_ni = 1'b0;
        load_ci = 1'b0;
        load_sc = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (bus.alu_valid) begin
                        load_en = 1'b1;
                        load_zi = bus.alu_z;
                        load_ni = bus.alu_n;
                        load_ci = bus.alu_c;
                    end else if (bus.setc) begin
                        load_en = 1'b1;
                        load_zi = bus.z;
                        load_ni = bus.n;
                        load_sc = 1'b1;
                    end else if (bus.clrc) begin
                        load_en = 1'b1;
                        load_zi = bus.z;
                        load_ni = bus.n;
                    end
                end
                RST_WR: begin
                    load_en = 1'b1;
                    load_zi = restore_data[FLAG_Z];
                    load_ni = restore_data[FLAG_N];
                    load_ci = restore_data[FLAG_C];
                end
                default: ;
            endcase
        end
    end

    // Restore sequencer with registered busy/rti_ack and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
`ifdef FLAGS_SHADOW_EN
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    // While an ack is showing the requester has not yet seen
                    // it, so a still-high rti_req belongs to the finished return.
                    if (bus.rti_req && !ack_q) begin
`ifdef FLAGS_SHADOW_EN
                        if (stack_empty) begin
                            ack_q <= 1'b1;
                            udf_q <= 1'b1;
                        end else begin
                            state  <= RST_RD;
                            busy_q <= 1'b1;
                        end
`else
                        ack_q <= 1'b1;
`endif
                    end
                end
                RST_RD: begin
                    state <= RST_WR;
                    ack_q <= 1'b1;
                end
                RST_WR: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
`ifdef FLAGS_SHADOW_EN
            if (push_drop) begin
                ovf_q <= 1'b1;
            end
`endif
        end
    end

endmodule
